mat_mult_sequencer: RTL

//  Sequences one signed matrix product C = A x B through the shared dot-product datapath.

---
 rtl/mat_pkg.sv | 76 +++++++
 rtl/mat_tag_pipe.sv | 42 ++++
 rtl/mat_mult_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared matrix types, FSM encoding and element/lane slicing helpers.
// Used by the sequencer, the dot-product datapath and the register layer.
package mat_pkg;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int MW = N * N * W;
  localparam int RW = N * W;
  localparam int MB = $clog2(MW);
  localparam int RB = $clog2(RW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } st_t;

  typedef logic [IW-1:0] ix_t;
  typedef logic [W-1:0]  el_t;
  typedef logic [MW-1:0] mat_t;
  typedef logic [RW-1:0] row_t;

  localparam ix_t NS = ix_t'(N);

  function automatic el_t el_get(mat_t m, ix_t r, ix_t c);
    logic [MB-1:0] b;
    b = MB'(MW - 1 - (int'(r) * N + int'(c)) * W);
    return m[b -: W];
  endfunction

  function automatic mat_t el_set(mat_t m, ix_t r, ix_t c, el_t v);
    mat_t o;
    logic [MB-1:0] b;
    o = m;
    b = MB'(MW - 1 - (int'(r) * N + int'(c)) * W);
    o[b -: W] = v;
    return o;
  endfunction

  function automatic row_t lane_set(row_t v, ix_t k, el_t e);
    row_t o;
    logic [RB-1:0] b;
    o = v;
    b = RB'(RW - 1 - int'(k) * W);
    o[b -: W] = e;
    return o;
  endfunction

  function automatic ix_t clamp(logic [2:0] sz);
    if (sz < 3'd2) return ix_t'(2);
    if (sz > NS) return NS;
    return ix_t'(sz);
  endfunction

  // lanes at or beyond the active size stay zero
  function automatic row_t row_of(mat_t m, ix_t i, ix_t s);
    row_t o;
    o = '0;
    for (int k = 0; k < N; k++)
      if (ix_t'(k) < s)
        o = lane_set(o, ix_t'(k), el_get(m, i, ix_t'(k)));
    return o;
  endfunction

  function automatic row_t col_of(mat_t m, ix_t j, ix_t s);
    row_t o;
    o = '0;
    for (int k = 0; k < N; k++)
      if (ix_t'(k) < s)
        o = lane_set(o, ix_t'(k), el_get(m, ix_t'(k), j));
    return o;
  endfunction

endpackage

// File: rtl/mat_tag_pipe.sv
// Delay line carrying {valid,i,j} alongside each datapath issue.
// LAT=0 degenerates to a wire.
module mat_tag_pipe
  import mat_pkg::*;
#(
  parameter int LAT = 1,
  parameter int TW  = 1 + 2 * IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] tin,
  output logic [TW-1:0] tout,
  output logic          pend
);

  if (LAT == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign tout = tin;
    assign pend = 1'b0;
  end else begin : g_pipe
    logic [TW-1:0] stg [LAT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < LAT; k++) stg[k] <= '0;
      end else begin
        stg[0] <= tin;
        for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
      end
    end

    assign tout = stg[LAT-1];

    // the output stage is captured this edge; only earlier stages are pending
    always_comb begin
      pend = 1'b0;
      for (int k = 0; k < LAT - 1; k++) pend = pend | stg[k][TW-1];
    end
  end

endmodule

// File: rtl/mat_mult_sequencer.sv
// Sequences C = A x B through the shared dot-product datapath,
// one row/column pair per cycle, with sticky overflow.
module mat_mult_sequencer
  import mat_pkg::*;
#(
  parameter int DP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    size,
  input  logic [MW-1:0] mat_a,
  input  logic [MW-1:0] mat_b,
  output logic          busy,
  output logic          done,
  output logic [MW-1:0] mat_c,
  output logic          ovf,
  output logic          dp_valid,
  output logic [RW-1:0] dp_row,
  output logic [RW-1:0] dp_col,
  input  logic [W-1:0]  dp_res,
  input  logic          dp_ovf
);

  localparam int TW = 1 + 2 * IW;

  st_t st, nst;
  mat_t a_q, b_q;
  ix_t s_q, i_q, j_q, ni, nj, sz;
  logic last, pend, go;
  logic [TW-1:0] tin, tout;

  assign sz   = clamp(size);
  assign go   = (st == IDLE) && start;
  assign last = (i_q == s_q - 1'b1) && (j_q == s_q - 1'b1);
  assign tin  = {dp_valid, i_q, j_q};

  always_comb begin
    ni = i_q;
    nj = j_q + 1'b1;
    if (j_q == s_q - 1'b1) begin
      ni = i_q + 1'b1;
      nj = '0;
    end
  end

  mat_tag_pipe #(.LAT(DP_LAT), .TW(TW)) u_tags (
    .clk  (clk),
    .rst  (rst),
    .tin  (tin),
    .tout (tout),
    .pend (pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:  if (start) nst = RUN;
      RUN:   if (last) nst = (DP_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (!pend) nst = DONE;
      DONE:  nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  assign busy = (st == RUN) || (st == DRAIN);
  assign done = (st == DONE);

  // first pair is issued straight from the inputs so it lands in cycle 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      dp_valid <= 1'b0;
      dp_row   <= '0;
      dp_col   <= '0;
    end else if (go) begin
      a_q      <= mat_a;
      b_q      <= mat_b;
      s_q      <= sz;
      i_q      <= '0;
      j_q      <= '0;
      dp_valid <= 1'b1;
      dp_row   <= row_of(mat_a, ix_t'(0), sz);
      dp_col   <= col_of(mat_b, ix_t'(0), sz);
    end else if (st == RUN) begin
      if (last) begin
        dp_valid <= 1'b0;
        dp_row   <= '0;
        dp_col   <= '0;
      end else begin
        i_q    <= ni;
        j_q    <= nj;
        dp_row <= row_of(a_q, ni, s_q);
        dp_col <= col_of(b_q, nj, s_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mat_c <= '0;
      ovf   <= 1'b0;
    end else if (go) begin
      mat_c <= '0;
      ovf   <= 1'b0;
    end else if (tout[TW-1]) begin
      mat_c <= el_set(mat_c, tout[2*IW-1:IW], tout[IW-1:0], dp_res);
      ovf   <= ovf | dp_ovf;
    end
  end

endmodule
